// File: rtl/axi4_lite_slave.sv
// axi4_lite_slave: AXI4-Lite register bank with independent write and read FSMs.
// Define AXIL_SLAVE_DECERR_EN to answer out-of-range accesses with DECERR instead of OKAY.
module axi4_lite_slave #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDRESS-1:0]             S_AWADDR,
  input  logic                           S_AWVALID,
  output logic                           S_AWREADY,
  input  logic [DATA_WIDTH-1:0]          S_WDATA,
  input  logic [3:0]                     S_WSTRB,
  input  logic                           S_WVALID,
  output logic                           S_WREADY,
  output logic [1:0]                     S_BRESP,
  output logic                           S_BVALID,
  input  logic                           S_BREADY,
  input  logic [ADDRESS-1:0]             S_ARADDR,
  input  logic                           S_ARVALID,
  output logic                           S_ARREADY,
  output logic [DATA_WIDTH-1:0]          S_RDATA,
  output logic [1:0]                     S_RRESP,
  output logic                           S_RVALID,
  input  logic                           S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_OUT
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [1:0] W_IDLE = 2'd0, W_WAIT_W = 2'd1, W_WAIT_A = 2'd2, W_RESP = 2'd3;
  localparam logic [0:0] R_IDLE = 1'b0, R_DATA = 1'b1;
  localparam logic [ADDRESS-1:0] LIMIT = ADDRESS'(NUM_REGS * 4);
  logic [1:0] w_state, w_next, w_resp, r_resp;
  logic [0:0] r_state;
  logic [ADDRESS-1:0] aw_q, w_addr;
  logic [DATA_WIDTH-1:0] wd_q, w_data;
  logic [3:0] ws_q, w_strb;
  logic aw_hs, w_hs, ar_hs, commit, w_in, r_in;
  assign S_AWREADY = w_state == W_IDLE || w_state == W_WAIT_A;
  assign S_WREADY  = w_state == W_IDLE || w_state == W_WAIT_W;
  assign S_BVALID  = w_state == W_RESP;
  assign S_ARREADY = r_state == R_IDLE;
  assign S_RVALID  = r_state == R_DATA;
  assign aw_hs = S_AWVALID && S_AWREADY;
  assign w_hs  = S_WVALID && S_WREADY;
  assign ar_hs = S_ARVALID && S_ARREADY;
  // The completing handshake may carry either half live on the bus; the other half comes from the latch.
  assign w_addr = aw_hs ? S_AWADDR : aw_q;
  assign w_data = w_hs ? S_WDATA : wd_q;
  assign w_strb = w_hs ? S_WSTRB : ws_q;
  assign w_in   = w_addr < LIMIT;
  assign r_in   = S_ARADDR < LIMIT;
`ifdef AXIL_SLAVE_DECERR_EN
  assign w_resp = w_in ? 2'b00 : 2'b11;
  assign r_resp = r_in ? 2'b00 : 2'b11;
`else
  assign w_resp = 2'b00;
  assign r_resp = 2'b00;
`endif
  always_comb
    w_next = (w_state == W_IDLE)   ? (aw_hs && w_hs ? W_RESP : aw_hs ? W_WAIT_W : w_hs ? W_WAIT_A : W_IDLE) :
             (w_state == W_WAIT_W) ? (w_hs ? W_RESP : W_WAIT_W) :
             (w_state == W_WAIT_A) ? (aw_hs ? W_RESP : W_WAIT_A) :
                                     (S_BREADY ? W_IDLE : W_RESP);
  assign commit = w_next == W_RESP && w_state != W_RESP;
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      w_state <= W_IDLE;
      aw_q    <= '0;
      wd_q    <= '0;
      ws_q    <= '0;
      S_BRESP <= 2'b00;
    end else begin
      w_state <= w_next;
      if (aw_hs) aw_q <= S_AWADDR;
      if (w_hs) begin
        wd_q <= S_WDATA;
        ws_q <= S_WSTRB;
      end
      if (commit) S_BRESP <= w_resp;
    end
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    logic [DATA_WIDTH-1:0] r;
    always_ff @(posedge ACLK)
      if (!ARESETN) r <= '0;
      else if (commit && w_in && w_addr[2 +: IW] == IW'(k))
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) r[8*b +: 8] <= w_data[8*b +: 8];
    assign REG_OUT[DATA_WIDTH*k +: DATA_WIDTH] = r;
  end
  // RDATA samples the pre-edge register image, so a same-edge write is not visible yet.
  always_ff @(posedge ACLK)
    if (!ARESETN) begin
      r_state <= R_IDLE;
      S_RDATA <= '0;
      S_RRESP <= 2'b00;
    end else begin
      r_state <= ar_hs ? R_DATA : (S_RVALID && S_RREADY) ? R_IDLE : r_state;
      if (ar_hs) begin
        S_RDATA <= r_in ? REG_OUT[DATA_WIDTH*S_ARADDR[2 +: IW] +: DATA_WIDTH] : '0;
        S_RRESP <= r_resp;
      end
    end
endmodule

// File: tb/tb_axi4_lite_slave.sv
// tb_axi4_lite_slave: randomized and directed bench with a response scoreboard and a register-array model.
module tb_axi4_lite_slave;
  localparam int NR = 8;
`ifdef AXIL_SLAVE_DECERR_EN
  localparam logic [1:0] ERR = 2'b11;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif
  logic ACLK = 0, ARESETN = 0;
  logic [31:0] S_AWADDR = 0, S_WDATA = 0, S_ARADDR = 0, S_RDATA;
  logic [3:0] S_WSTRB = 0;
  logic S_AWVALID = 0, S_WVALID = 0, S_ARVALID = 0, S_BREADY = 1, S_RREADY = 1;
  logic S_AWREADY, S_WREADY, S_BVALID, S_ARREADY, S_RVALID;
  logic [1:0] S_BRESP, S_RRESP;
  logic [NR*32-1:0] REG_OUT;
  int tests = 0, fails = 0;
  logic [31:0] model [NR];
  logic [1:0] bq [$];
  logic [33:0] rq [$];
  axi4_lite_slave #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(NR)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .REG_OUT(REG_OUT)
  );
  always #5 ACLK = ~ACLK;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Monitor: every B/R handshake pops the oldest expected response.
  always @(negedge ACLK)
    if (ARESETN) begin
      if (S_BVALID && S_BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", S_BVALID, 0);
        else chk("bresp", S_BRESP, bq.pop_front());
      end
      if (S_RVALID && S_RREADY) begin
        if (rq.size() == 0) chk("r_unexpected", S_RVALID, 0);
        else begin
          logic [33:0] e;
          e = rq.pop_front();
          chk("rdata", S_RDATA, e[31:0]);
          chk("rresp", S_RRESP, e[33:32]);
        end
      end
    end
  task automatic chk_regs();
    for (int k = 0; k < NR; k++) chk("reg_out", REG_OUT[32*k +: 32], model[k]);
  endtask
  // mode 0: AW and W together; 1: AW first, W after gap cycles; 2: W first, AW after gap cycles.
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int mode, input int gap);
    bit aw_on, w_on, aw_done, w_done, awh, wh;
    int cyc;
    if (a < NR*4) begin
      for (int i = 0; i < 4; i++) if (s[i]) model[a[2 +: 3]][8*i +: 8] = d[8*i +: 8];
      bq.push_back(2'b00);
    end else bq.push_back(ERR);
    aw_on = mode != 2; w_on = mode != 1; aw_done = 0; w_done = 0; cyc = 0;
    if (aw_on) begin S_AWADDR = a; S_AWVALID = 1; end
    if (w_on) begin S_WDATA = d; S_WSTRB = s; S_WVALID = 1; end
    while (!(aw_done && w_done) && cyc < 50) begin
      @(negedge ACLK);
      if (!w_on) begin
        chk("wready_wait_w", S_WREADY, 1);
        if (aw_done) chk("awready_wait_w", S_AWREADY, 0);
      end
      if (!aw_on) begin
        chk("awready_wait_a", S_AWREADY, 1);
        if (w_done) chk("wready_wait_a", S_WREADY, 0);
      end
      awh = S_AWVALID && S_AWREADY;
      wh = S_WVALID && S_WREADY;
      @(posedge ACLK); #1;
      if (awh) begin S_AWVALID = 0; aw_done = 1; end
      if (wh) begin S_WVALID = 0; w_done = 1; end
      cyc++;
      if (cyc == gap && !aw_on) begin S_AWADDR = a; S_AWVALID = 1; aw_on = 1; end
      if (cyc == gap && !w_on) begin S_WDATA = d; S_WSTRB = s; S_WVALID = 1; w_on = 1; end
    end
    chk("wr_handshakes", {aw_done, w_done}, 2'b11);
    chk("bvalid_latency", S_BVALID, 1);
  endtask
  task automatic wait_b();
    for (int i = 0; i < 20 && S_BVALID; i++) begin @(posedge ACLK); #1; end
    chk("b_done", S_BVALID, 0);
  endtask
  task automatic rd(input logic [31:0] a);
    bit arh;
    int cyc;
    rq.push_back(a < NR*4 ? {2'b00, model[a[2 +: 3]]} : {ERR, 32'h0});
    S_ARADDR = a; S_ARVALID = 1; arh = 0; cyc = 0;
    while (!arh && cyc < 50) begin
      @(negedge ACLK);
      arh = S_ARREADY;
      @(posedge ACLK); #1;
      cyc++;
    end
    S_ARVALID = 0;
    chk("ar_handshake", arh, 1);
    chk("rvalid_latency", S_RVALID, 1);
  endtask
  task automatic wait_r();
    for (int i = 0; i < 20 && S_RVALID; i++) begin @(posedge ACLK); #1; end
    chk("r_done", S_RVALID, 0);
  endtask
  initial begin
    for (int k = 0; k < NR; k++) model[k] = 0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_awready", S_AWREADY, 1);
    chk("rst_wready", S_WREADY, 1);
    chk("rst_arready", S_ARREADY, 1);
    chk("rst_bvalid", S_BVALID, 0);
    chk("rst_rvalid", S_RVALID, 0);
    chk("rst_bresp", S_BRESP, 0);
    chk("rst_rresp", S_RRESP, 0);
    chk("rst_rdata", S_RDATA, 0);
    chk_regs();
    ARESETN = 1;
    @(posedge ACLK); #1;
    wr(32'h4, 32'hDEADBEEF, 4'hF, 0, 1); wait_b();
    rd(32'h4); wait_r();
    chk("reg1_deadbeef", REG_OUT[63:32], 32'hDEADBEEF);
    wr(32'h8, 32'h11223344, 4'hF, 0, 1); wait_b();
    wr(32'h8, 32'hAABBCCDD, 4'b0101, 0, 1); wait_b();
    rd(32'h8); wait_r();
    chk("partial_strobe", REG_OUT[95:64], 32'h11BB33DD);
    wr(32'h8, 32'h5A5A5A5A, 4'hF, 1, 3); wait_b();
    chk("aw_first", REG_OUT[95:64], 32'h5A5A5A5A);
    wr(32'h8, 32'h0, 4'hF, 0, 1); wait_b();
    wr(32'h8, 32'h5A5A5A5A, 4'hF, 2, 3); wait_b();
    chk("w_first", REG_OUT[95:64], 32'h5A5A5A5A);
    S_BREADY = 0;
    wr(32'h18, 32'h12345678, 4'hF, 0, 1);
    repeat (5) begin
      @(negedge ACLK);
      chk("bhold_valid", S_BVALID, 1);
      chk("bhold_resp", S_BRESP, 0);
      chk("bhold_awready", S_AWREADY, 0);
      chk("bhold_wready", S_WREADY, 0);
    end
    @(posedge ACLK); #1;
    S_BREADY = 1; wait_b();
    S_RREADY = 0;
    rd(32'h18);
    repeat (5) begin
      @(negedge ACLK);
      chk("rhold_valid", S_RVALID, 1);
      chk("rhold_data", S_RDATA, 32'h12345678);
      chk("rhold_arready", S_ARREADY, 0);
    end
    @(posedge ACLK); #1;
    S_RREADY = 1; wait_r();
    wr(32'h40, 32'hFFFFFFFF, 4'hF, 0, 1); wait_b();
    chk_regs();
    rd(32'h40); wait_r();
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 5) == 0) ? 32'h40 + 4*$urandom_range(0, 7) : 4*$urandom_range(0, 7) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        wr(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(1, 3));
        wait_b();
        chk_regs();
      end else begin
        rd(a); wait_r();
      end
    end
    wr(32'hC, 32'h1, 4'hF, 0, 1); wait_b();
    rq.push_back({2'b00, model[3]});
    model[3] = 32'h2;
    bq.push_back(2'b00);
    S_AWADDR = 32'hC; S_WDATA = 32'h2; S_WSTRB = 4'hF; S_ARADDR = 32'hC;
    S_AWVALID = 1; S_WVALID = 1; S_ARVALID = 1;
    @(posedge ACLK); #1;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
    chk("coll_bvalid", S_BVALID, 1);
    chk("coll_rvalid", S_RVALID, 1);
    chk("coll_rdata_old", S_RDATA, 32'h1);
    wait_b(); wait_r();
    rd(32'hC); wait_r();
    chk("coll_reg3", REG_OUT[127:96], 32'h2);
    S_BREADY = 0;
    wr(32'h10, 32'hCAFE0001, 4'hF, 0, 1);
    @(posedge ACLK); #1;
    ARESETN = 0;
    bq.delete();
    for (int k = 0; k < NR; k++) model[k] = 0;
    @(posedge ACLK); #1;
    chk("rst_mid_bvalid", S_BVALID, 0);
    chk_regs();
    ARESETN = 1; S_BREADY = 1;
    S_AWADDR = 32'h14; S_AWVALID = 1;
    @(posedge ACLK); #1;
    S_AWVALID = 0; ARESETN = 0;
    @(posedge ACLK); #1;
    ARESETN = 1;
    chk("rst_abort_awready", S_AWREADY, 1);
    S_WDATA = 32'h77; S_WSTRB = 4'hF; S_WVALID = 1;
    @(posedge ACLK); #1;
    S_WVALID = 0;
    @(posedge ACLK); #1;
    chk("rst_abort_no_b", S_BVALID, 0);
    chk_regs();
    ARESETN = 0;
    @(posedge ACLK); #1;
    ARESETN = 1;
    repeat (2) @(posedge ACLK);
    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/axi4_lite_slave.md
Name: axi4_lite_slave

Overview:
- AXI4-Lite responder: a memory-mapped bank of NUM_REGS registers, each DATA_WIDTH bits, serviced over the standard five channels.
- Acts as the completer end for our AXI4-Lite master block: control/status register space behind the interconnect.
- Write path (AW/W/B) and read path (AR/R) run as independent FSMs and may be active concurrently.
- Register contents are exported flat to the fabric.

Parameters:
- ADDRESS, 32: AXI address width.
- DATA_WIDTH, 32: data width. Fixed at 32; WSTRB is 4 bits.
- NUM_REGS, 8: number of registers. Power of two, 2..256.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESETN  in  1  reset, synchronous, active-low.
- S_AWADDR  in  ADDRESS  write address.
- S_AWVALID  in  1  write address valid.
- S_AWREADY  out  1  write address ready.
- S_WDATA  in  DATA_WIDTH  write data.
- S_WSTRB  in  4  byte strobes; bit i enables WDATA[8i+7:8i].
- S_WVALID  in  1  write data valid.
- S_WREADY  out  1  write data ready.
- S_BRESP  out  2  write response.
- S_BVALID  out  1  write response valid.
- S_BREADY  in  1  write response ready.
- S_ARADDR  in  ADDRESS  read address.
- S_ARVALID  in  1  read address valid.
- S_ARREADY  out  1  read address ready.
- S_RDATA  out  DATA_WIDTH  read data.
- S_RRESP  out  2  read response.
- S_RVALID  out  1  read valid.
- S_RREADY  in  1  read ready.
- REG_OUT  out  NUM_REGS*DATA_WIDTH  register contents; reg k at bits [32k+31:32k].

Behaviour:
- Reset (ARESETN=0 at a clock edge): both FSMs go to IDLE, all registers go to 0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0.
- Reset mid-transaction aborts it. No response is issued and no partial write is committed.
- Decode:
  - index = addr[2 +: log2(NUM_REGS)]; addr[1:0] is ignored.
  - An address is in range iff addr < NUM_REGS*4.
- Write FSM states and transitions:
  - W_IDLE: AWREADY=1, WREADY=1.
    - AW and W both handshake -> W_RESP.
    - AW only: latch address -> W_WAIT_W.
    - W only: latch data and strobes -> W_WAIT_A.
  - W_WAIT_W: AWREADY=0, WREADY=1. W handshake -> W_RESP.
  - W_WAIT_A: AWREADY=1, WREADY=0. AW handshake -> W_RESP.
  - W_RESP: AWREADY=WREADY=0, BVALID=1. BRESP is held stable until the BREADY handshake -> W_IDLE.
- Write commit:
  - Occurs on the edge entering W_RESP.
  - Only strobed bytes of the addressed register update.
  - An out-of-range write updates nothing.
  - BVALID is asserted the cycle after the completing handshake: latency 1 from the AW+W same-cycle case.
- Read FSM states and transitions:
  - R_IDLE: ARREADY=1. AR handshake: RDATA is registered from the addressed register -> R_DATA.
  - R_DATA: ARREADY=0, RVALID=1. RDATA/RRESP are held until the RREADY handshake -> R_IDLE.
  - Read latency: RVALID 1 cycle after the AR handshake.
- Out-of-range read: RDATA=0.
- Response codes: OKAY (2'b00) unless the optional feature is enabled.
- Simultaneous write commit and read capture on the same register in the same edge: read returns the pre-write value.
- No back-to-back pipelining:
  - A new AW/W is not accepted while BVALID=1.
  - A new AR is not accepted while RVALID=1.
- READY signals are never withdrawn while the same state persists; VALID outputs are never dropped before their handshake.

Optional Feature:
- Macro AXIL_SLAVE_DECERR_EN.
- Defined: out-of-range accesses return BRESP/RRESP = 2'b11 (DECERR). Write is still dropped; RDATA is still 0.
- Undefined: out-of-range accesses return 2'b00 (OKAY), silently dropped/zero. This saves the decode compare on the response path.

Test Plan:
- Write addr 0x4, data 0xDEADBEEF, WSTRB 4'hF, AW+W same cycle -> BVALID next cycle, BRESP 00. Then read 0x4 -> RVALID 1 cycle after AR, RDATA 0xDEADBEEF, REG_OUT[63:32]=0xDEADBEEF.
- Partial strobe: reg 2 = 0x11223344, write 0xAABBCCDD with WSTRB 4'b0101 -> read returns 0x11BB33DD.
- Ordering:
  - AW to 0x8 three cycles before W (data 0x5A5A5A5A) -> WREADY held 1, BVALID after W handshake, reg 2 = 0x5A5A5A5A.
  - Repeat with W first -> same result.
- Backpressure: hold BREADY=0 for 5 cycles, then RREADY=0 for 5 cycles -> BVALID/RVALID and BRESP/RDATA stable; AWREADY=WREADY=0 and ARREADY=0 respectively during the hold.
- Out-of-range: write/read 0x40 with NUM_REGS=8 -> no register changes, RDATA 0. Response 00 without AXIL_SLAVE_DECERR_EN, 11 with it.
- Same-edge collision: reg 3 = 0x1, write 0x2 and AR to 0xC captured on the same edge -> RDATA 0x1, subsequent read 0x2. Assert ARESETN=0 while BVALID=1 -> BVALID=0, all REG_OUT=0 next cycle.
